// File: rtl/cmp_range_seq.sv
// -----------------------------------------------------------------------------
// cmp_range_seq
//   Sequential range checker that sits directly upstream of the 16-bit cmp
//   block. One cmp instance is time-multiplexed: x is compared against lo
//   first, then against hi. The cmp gt/eq/lt answers are turned into
//   below / above / in_range / at_edge flags.
//
//   Optional feature macro: CMP_RANGE_CHECK_EN
//     defined   : while comparing, a cmp answer that is not exactly one-hot
//                 sets the sticky cmp_err flag. cmp_err stays set until rst_n.
//     undefined : cmp_err is tied to 0 and no check logic is built.
//
// Parameters
//   WIDTH      operand width; must be 16 to match cmp
//   INCLUSIVE  1: in_range means lo <= x <= hi, 0: lo < x < hi
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   in_valid/in_ready              request handshake
//   in_x, in_lo, in_hi, in_sign    request payload (sign=1: signed compare)
//   cmp_a, cmp_b, cmp_sign         registered operands driven into cmp
//   cmp_gt, cmp_eq, cmp_lt         answers from cmp (A vs B)
//   out_valid/out_ready            result handshake, result held until taken
//   below, above, in_range, at_edge  result flags
//   cmp_err                        sticky cmp sanity error
// -----------------------------------------------------------------------------
module cmp_range_seq #(
  parameter int WIDTH     = 16,
  parameter bit INCLUSIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_hi,
  input  logic             in_sign,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_sign,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             below,
  output logic             above,
  output logic             in_range,
  output logic             at_edge,
  output logic             cmp_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CMP_LO = 2'd1;
  localparam logic [1:0] ST_CMP_HI = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             accept_s;

  // cmp_a_r and cmp_sign_r double as the latched x and sign operands; cmp_b_r
  // holds lo during CMP_LO and is reloaded from hi_r for CMP_HI.
  logic [WIDTH-1:0] cmp_a_r;
  logic [WIDTH-1:0] cmp_b_r;
  logic             cmp_sign_r;
  logic [WIDTH-1:0] hi_r;

  logic             lt_lo_r;
  logic             eq_lo_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             below_r;
  logic             above_r;
  logic             in_range_r;
  logic             at_edge_r;

  logic             below_nxt_s;
  logic             above_nxt_s;
  logic             in_range_nxt_s;
  logic             at_edge_nxt_s;
  logic             edge_hi_s;

  assign accept_s = in_valid & (state_r == ST_IDLE);

  // Next-state and result-flag computation; flags only change on entry to RESULT
  always_comb begin
    state_nxt_s    = state_r;
    below_nxt_s    = below_r;
    above_nxt_s    = above_r;
    in_range_nxt_s = in_range_r;
    at_edge_nxt_s  = at_edge_r;
    edge_hi_s      = eq_lo_r | cmp_eq;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_CMP_LO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMP_LO: begin
        if (cmp_lt) begin
          // Early exit: x is below lo, hi is never examined.
          state_nxt_s    = ST_RESULT;
          below_nxt_s    = 1'b1;
          above_nxt_s    = 1'b0;
          at_edge_nxt_s  = cmp_eq;
          in_range_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_CMP_HI;
        end
      end
      ST_CMP_HI: begin
        state_nxt_s    = ST_RESULT;
        below_nxt_s    = lt_lo_r;
        above_nxt_s    = cmp_gt;
        at_edge_nxt_s  = edge_hi_s;
        in_range_nxt_s = ~lt_lo_r & ~cmp_gt & (INCLUSIVE | ~edge_hi_s);
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus the handshake outputs, which follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_RESULT);
    end
  end

  // Operand latches and cmp drive registers; they hold outside of a compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_a_r    <= {WIDTH{1'b0}};
      cmp_b_r    <= {WIDTH{1'b0}};
      cmp_sign_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cmp_a_r    <= in_x;
      cmp_b_r    <= in_lo;
      cmp_sign_r <= in_sign;
      hi_r       <= in_hi;
    end else if ((state_r == ST_CMP_LO) && !cmp_lt) begin
      cmp_b_r    <= hi_r;
    end
  end

  // Capture the x-vs-lo answer for use when the hi answer arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_lo_r <= 1'b0;
      eq_lo_r <= 1'b0;
    end else if (state_r == ST_CMP_LO) begin
      lt_lo_r <= cmp_lt;
      eq_lo_r <= cmp_eq;
    end
  end

  // Result flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      below_r    <= 1'b0;
      above_r    <= 1'b0;
      in_range_r <= 1'b0;
      at_edge_r  <= 1'b0;
    end else begin
      below_r    <= below_nxt_s;
      above_r    <= above_nxt_s;
      in_range_r <= in_range_nxt_s;
      at_edge_r  <= at_edge_nxt_s;
    end
  end

`ifdef CMP_RANGE_CHECK_EN
  logic cmp_err_r;

  // A healthy cmp raises exactly one of gt/eq/lt.
  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) | (v == 3'b010) | (v == 3'b100);
  endfunction

  // Sticky error: set on any non-one-hot answer while a compare is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_err_r <= 1'b0;
    end else if (((state_r == ST_CMP_LO) || (state_r == ST_CMP_HI)) &&
                 !is_one_hot3({cmp_gt, cmp_eq, cmp_lt})) begin
      cmp_err_r <= 1'b1;
    end
  end

  assign cmp_err = cmp_err_r;
`else
  assign cmp_err = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign cmp_a     = cmp_a_r;
  assign cmp_b     = cmp_b_r;
  assign cmp_sign  = cmp_sign_r;
  assign below     = below_r;
  assign above     = above_r;
  assign in_range  = in_range_r;
  assign at_edge   = at_edge_r;

endmodule

// File: tb/tb_cmp_range_seq.sv
// -----------------------------------------------------------------------------
// tb_cmp_range_seq
//   Directed bench for cmp_range_seq. Two instances run in lockstep on the same
//   request stream: u_inc (INCLUSIVE=1) and u_exc (INCLUSIVE=0). Each has its
//   own behavioural cmp model; force_bad makes both models answer gt=eq=1.
// -----------------------------------------------------------------------------
module tb_cmp_range_seq;

`ifdef CMP_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = 16'h0000;
  logic [15:0] in_lo = 16'h0000;
  logic [15:0] in_hi = 16'h0000;
  logic        in_sign = 1'b0;
  logic        out_ready = 1'b0;
  logic        force_bad = 1'b0;

  logic        in_ready0, out_valid0, below0, above0, in_range0, at_edge0, cmp_err0;
  logic [15:0] cmp_a0, cmp_b0;
  logic        cmp_sign0, gt0, eq0, lt0;
  logic        in_ready1, out_valid1, below1, above1, in_range1, at_edge1, cmp_err1;
  logic [15:0] cmp_a1, cmp_b1;
  logic        cmp_sign1, gt1, eq1, lt1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] cmp_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic g, l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    return {g, (a == b), l};
  endfunction

  always_comb begin
    {gt0, eq0, lt0} = force_bad ? 3'b110 : cmp_fn(cmp_a0, cmp_b0, cmp_sign0);
    {gt1, eq1, lt1} = force_bad ? 3'b110 : cmp_fn(cmp_a1, cmp_b1, cmp_sign1);
  end

  cmp_range_seq #(.WIDTH(16), .INCLUSIVE(1'b1)) u_inc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_x(in_x), .in_lo(in_lo), .in_hi(in_hi), .in_sign(in_sign),
    .cmp_a(cmp_a0), .cmp_b(cmp_b0), .cmp_sign(cmp_sign0),
    .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .below(below0), .above(above0), .in_range(in_range0), .at_edge(at_edge0),
    .cmp_err(cmp_err0)
  );

  cmp_range_seq #(.WIDTH(16), .INCLUSIVE(1'b0)) u_exc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_x(in_x), .in_lo(in_lo), .in_hi(in_hi), .in_sign(in_sign),
    .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_sign(cmp_sign1),
    .cmp_gt(gt1), .cmp_eq(eq1), .cmp_lt(lt1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .below(below1), .above(above1), .in_range(in_range1), .at_edge(at_edge1),
    .cmp_err(cmp_err1)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles after the accept edge until out_valid (cycle 1 = first cycle
  // after accept). Returns 0 on timeout. Also reports whether hi reached cmp_b.
  task automatic wait_result(input logic [15:0] hi, input logic [15:0] lo,
                             output int lat, output logic saw_hi);
    lat = 0;
    saw_hi = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if ((cmp_b0 === hi) && (hi !== lo)) saw_hi = 1'b1;
      if (out_valid0 === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic check_flags(input string name, input logic eb, input logic ea,
                             input logic ee, input logic er1, input logic er0);
    n_cmp++;
    if ({below0, above0, at_edge0, in_range0} !== {eb, ea, ee, er1}) begin
      n_fail++;
      $display("FAIL %s flags_inc: below/above/at_edge/in_range got %b%b%b%b want %b%b%b%b",
               name, below0, above0, at_edge0, in_range0, eb, ea, ee, er1);
    end
    n_cmp++;
    if ({out_valid1, below1, above1, at_edge1, in_range1} !== {1'b1, eb, ea, ee, er0}) begin
      n_fail++;
      $display("FAIL %s flags_exc: valid/below/above/at_edge/in_range got %b%b%b%b%b want %b%b%b%b%b",
               name, out_valid1, below1, above1, at_edge1, in_range1, 1'b1, eb, ea, ee, er0);
    end
  endtask

  // One full request with out_ready held high.
  task automatic run_req(input string name, input logic [15:0] x, input logic [15:0] lo,
                         input logic [15:0] hi, input logic s, input int exp_lat,
                         input logic eb, input logic ea, input logic ee,
                         input logic er1, input logic er0);
    int   lat;
    logic saw_hi;
    n_cmp++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s in_ready_idle: got %b%b want 11", name, in_ready0, in_ready1);
    end
    in_valid = 1'b1; in_x = x; in_lo = lo; in_hi = hi; in_sign = s; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(hi, lo, lat, saw_hi);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, exp_lat);
    end
    n_cmp++;
    if (saw_hi !== ((exp_lat == 3) && (hi !== lo))) begin
      n_fail++;
      $display("FAIL %s cmp_b_hi_seen: got %b want %b", name, saw_hi,
               ((exp_lat == 3) && (hi !== lo)));
    end
    n_cmp++;
    if ({cmp_a0, cmp_sign0} !== {x, s}) begin
      n_fail++;
      $display("FAIL %s cmp_a_sign: got %h/%b want %h/%b", name, cmp_a0, cmp_sign0, x, s);
    end
    check_flags(name, eb, ea, ee, er1, er0);
    tick();
    n_cmp++;
    if ({out_valid0, in_ready0} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s after_consume: out_valid/in_ready got %b%b want 01",
               name, out_valid0, in_ready0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({in_ready0, out_valid0, below0, above0, in_range0, at_edge0, cmp_err0,
         cmp_a0, cmp_b0, cmp_sign0} !== {1'b1, 6'b0, 16'h0000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b flags=%b%b%b%b err=%b a=%h b=%h s=%b",
               in_ready0, out_valid0, below0, above0, in_range0, at_edge0, cmp_err0,
               cmp_a0, cmp_b0, cmp_sign0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_req("inside_unsigned", 16'h0050, 16'h0010, 16'h00F0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_req("early_exit",      16'h0005, 16'h0010, 16'h00F0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sign();
    run_req("signed_inside",   16'hFFFE, 16'hFFF0, 16'h0003, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_req("unsigned_above",  16'hFFFE, 16'hFFF0, 16'h0003, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_edges();
    run_req("x_eq_lo",   16'h1234, 16'h1234, 16'h2000, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_req("x_eq_hi",   16'h00F0, 16'h0010, 16'h00F0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_req("all_equal", 16'h7777, 16'h7777, 16'h7777, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_req("swap_below", 16'h0050, 16'h0080, 16'h0010, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("swap_above", 16'h0090, 16'h0080, 16'h0010, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic saw_hi;
    in_valid = 1'b1; in_x = 16'h0050; in_lo = 16'h0010; in_hi = 16'h00F0; in_sign = 1'b0;
    out_ready = 1'b0;
    tick();
    // Second request presented immediately and kept valid.
    in_x = 16'h0005;
    wait_result(16'h00F0, 16'h0010, lat, saw_hi);
    n_cmp++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL b2b_latency_a: got %0d want 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out_valid0, in_ready0, below0, above0, at_edge0, in_range0} !== 6'b100001) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: vld/rdy/below/above/edge/inr got %b%b%b%b%b%b want 100001",
                 i, out_valid0, in_ready0, below0, above0, at_edge0, in_range0);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid0, in_ready0, cmp_a0} !== {2'b01, 16'h0050}) begin
      n_fail++;
      $display("FAIL b2b_consume: vld/rdy got %b%b cmp_a %h want 01 0050",
               out_valid0, in_ready0, cmp_a0);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready0, cmp_a0, cmp_b0} !== {1'b0, 16'h0005, 16'h0010}) begin
      n_fail++;
      $display("FAIL b2b_accept_b: rdy %b a %h b %h want 0 0005 0010", in_ready0, cmp_a0, cmp_b0);
    end
    wait_result(16'h00F0, 16'h0010, lat, saw_hi);
    n_cmp++;
    if ({lat, saw_hi} !== {32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_latency_b: got %0d hi_seen %b want 2 0", lat, saw_hi);
    end
    check_flags("b2b_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_midop();
    logic seen_valid;
    in_valid = 1'b1; in_x = 16'h0050; in_lo = 16'h0010; in_hi = 16'h00F0; in_sign = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    // Now in CMP_HI; earlier result left below=1 in the flag registers.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready0, out_valid0, below0, above0, in_range0, at_edge0,
         cmp_a0, cmp_b0, cmp_sign0} !== {1'b1, 5'b0, 16'h0000, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midop: rdy=%b vld=%b flags=%b%b%b%b a=%h b=%h s=%b",
               in_ready0, out_valid0, below0, above0, in_range0, at_edge0,
               cmp_a0, cmp_b0, cmp_sign0);
    end
    #2;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid0 === 1'b1) seen_valid = 1'b1;
    end
    n_cmp++;
    if ({seen_valid, in_ready0} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_no_result: out_valid_seen %b in_ready %b want 0 1",
               seen_valid, in_ready0);
    end
  endtask

  task automatic test_cmp_err();
    in_valid = 1'b1; in_x = 16'h0050; in_lo = 16'h0010; in_hi = 16'h00F0; in_sign = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    n_cmp++;
    if ({cmp_err0, cmp_err1} !== {EXP_ERR, EXP_ERR}) begin
      n_fail++;
      $display("FAIL cmp_err_set: got %b%b want %b%b", cmp_err0, cmp_err1, EXP_ERR, EXP_ERR);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_err_result_valid: got %b want 1", out_valid0);
    end
    // Forced eq in CMP_LO is captured, so at_edge=1 with the range still inside.
    check_flags("cmp_err_result", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    run_req("after_err", 16'h0050, 16'h0010, 16'h00F0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (cmp_err0 !== EXP_ERR) begin
      n_fail++;
      $display("FAIL cmp_err_sticky: got %b want %b", cmp_err0, EXP_ERR);
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (cmp_err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL cmp_err_cleared: got %b want 0", cmp_err0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_sign();
    test_edges();
    test_back_to_back();
    test_reset_midop();
    test_cmp_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
